// File: rtl/huf_fix_enc.sv
// Deflate fixed-Huffman (BTYPE=01) encoder: turns LZ77 tokens into a
// byte-padded LSB-first bitstream delivered as 32-bit words.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start_i
// ST_HDR   | push BFINAL=1, BTYPE=01 (stream bits 1,1,0)
// ST_RUN   | accept one token per cycle until flg_lst_i
// ST_EOB   | push the 7-bit end-of-block code (all zeros)
// ST_FLUSH | drain full words, then emit padded last word with lst_o
module huf_fix_enc #(
    parameter int DATA_CHN_WD = 8,
    parameter int SIZE_LEN_WD = 9,
    parameter int SIZE_DST_WD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   done_o,
    input  logic                   val_i,
    input  logic                   flg_lit_i,
    input  logic [DATA_CHN_WD-1:0] dat_lit_i,
    input  logic [SIZE_LEN_WD-1:0] dat_len_i,
    input  logic [SIZE_DST_WD-1:0] dat_dst_i,
    input  logic                   flg_lst_i,
    output logic                   val_o,
    output logic [31:0]            dat_o,
    output logic [2:0]             byt_o,
    output logic                   lst_o
);

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_RUN, ST_EOB, ST_FLUSH} state_t;

    function automatic logic [3:0] msb_idx(input logic [14:0] v);
        msb_idx = 4'd0;
        for (int i = 0; i < 15; i++)
            if (v[i]) msb_idx = 4'(i);
    endfunction

    state_t      state_q, state_d;
    logic        s1_val_q, s1_val_d;
    logic [30:0] s1_bits_q, s1_bits_d;
    logic [4:0]  s1_nb_q, s1_nb_d;
    logic [63:0] buf_q, buf_d, sh_buf;
    logic [6:0]  fill_q, fill_d, sh_fill;
    logic        done_q, done_d;
    logic        emit, last, wout;

    logic [7:0]  lit_c;
    logic [8:0]  lit_code, lit_rev9, lit_rev;
    logic [3:0]  lit_nb;
    logic [8:0]  len_c;
    logic [7:0]  lm3, lcode, lrev8, lcr;
    logic [3:0]  lp, lnb;
    logic [2:0]  lk;
    logic [1:0]  lm;
    logic [4:0]  lsym, lx;
    logic [14:0] dm1;
    logic [3:0]  dp, dk;
    logic [4:0]  dcode, dcr;
    logic [12:0] dx;
    logic [4:0]  sh_d, sh_x;
    logic [30:0] tok_bits;
    logic [4:0]  tok_nb;

    always_comb begin : lookup
        lit_c = 8'(dat_lit_i);
        if (lit_c < 8'd144) begin
            lit_code = 9'h030 + 9'(lit_c);
            lit_nb   = 4'd8;
        end else begin
            lit_code = 9'h190 + 9'(lit_c - 8'd144);
            lit_nb   = 4'd9;
        end
        lit_rev9 = {<<{lit_code}};
        lit_rev  = lit_rev9 >> (4'd9 - lit_nb);

        // Out-of-range lengths/distances are clamped so a token never exceeds 31 bits.
        if (dat_len_i < SIZE_LEN_WD'(3))
            len_c = 9'd3;
        else if (dat_len_i > SIZE_LEN_WD'(258))
            len_c = 9'd258;
        else
            len_c = 9'(dat_len_i);
        lm3  = 8'(len_c - 9'd3);
        lp   = msb_idx({7'd0, lm3});
        lk   = 3'd0;
        lm   = 2'd0;
        lsym = 5'd0;
        lx   = 5'd0;
        if (len_c == 9'd258) begin
            lcode = 8'hC5;
            lnb   = 4'd8;
        end else if (lm3 < 8'd8) begin
            lcode = lm3 + 8'd1;
            lnb   = 4'd7;
        end else begin
            lk   = 3'(lp - 4'd2);
            lm   = 2'(lm3 >> lk);
            lsym = 5'd5 + {lk, 2'b00} + 5'(lm);
            lx   = 5'(lm3 & ((8'd1 << lk) - 8'd1));
            if (lsym < 5'd24) begin
                lcode = 8'(lsym);
                lnb   = 4'd7;
            end else begin
                lcode = 8'hC0 + 8'(lsym - 5'd24);
                lnb   = 4'd8;
            end
        end
        lrev8 = {<<{lcode}};
        lcr   = lrev8 >> (4'd8 - lnb);

        if (dat_dst_i == '0)
            dm1 = 15'd0;
        else if (dat_dst_i > SIZE_DST_WD'(32768))
            dm1 = 15'h7FFF;
        else
            dm1 = 15'(dat_dst_i - 1'b1);
        dp = msb_idx(dm1);
        dk = 4'd0;
        dx = 13'd0;
        if (dm1 < 15'd4) begin
            dcode = 5'(dm1);
        end else begin
            dk    = dp - 4'd1;
            dcode = {dp, dm1[dk]};
            dx    = 13'(dm1 & ((15'd1 << dk) - 15'd1));
        end
        dcr = {<<{dcode}};

        sh_d = 5'(lnb) + 5'(lk);
        sh_x = sh_d + 5'd5;
        if (flg_lit_i) begin
            tok_bits = 31'(lit_rev);
            tok_nb   = 5'(lit_nb);
        end else begin
            tok_bits = 31'(lcr) | (31'(lx) << lnb) | (31'(dcr) << sh_d) | (31'(dx) << sh_x);
            tok_nb   = sh_x + 5'(dk);
        end
    end

    always_comb begin : ctrl
        state_d   = state_q;
        s1_val_d  = 1'b0;
        s1_bits_d = '0;
        s1_nb_d   = '0;
        last      = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_HDR;
            ST_HDR: begin
                s1_val_d  = 1'b1;
                s1_bits_d = 31'd3;
                s1_nb_d   = 5'd3;
                state_d   = ST_RUN;
            end
            ST_RUN: if (val_i) begin
                s1_val_d  = 1'b1;
                s1_bits_d = tok_bits;
                s1_nb_d   = tok_nb;
                if (flg_lst_i) state_d = ST_EOB;
            end
            ST_EOB: begin
                s1_val_d = 1'b1;
                s1_nb_d  = 5'd7;
                state_d  = ST_FLUSH;
            end
            ST_FLUSH: if (!s1_val_q && fill_q <= 7'd32) begin
                last    = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        emit = !last && (fill_q >= 7'd32);
        // Shift out the emitted word first, then append behind what remains.
        sh_buf  = (emit || last) ? {32'd0, buf_q[63:32]} : buf_q;
        sh_fill = emit ? (fill_q - 7'd32) : (last ? 7'd0 : fill_q);
        buf_d   = sh_buf;
        fill_d  = sh_fill;
        if (s1_val_q) begin
            buf_d  = sh_buf | (64'(s1_bits_q) << sh_fill);
            fill_d = sh_fill + 7'(s1_nb_q);
        end

        wout  = (emit || last) && !rst;
        val_o = wout;
        dat_o = wout ? buf_q[31:0] : 32'd0;
        lst_o = last && !rst;
        if (!wout)
            byt_o = 3'd0;
        else if (emit)
            byt_o = 3'd4;
        else
            byt_o = 3'((fill_q + 7'd7) >> 3);
    end

    assign done_o = done_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s1_val_q  <= 1'b0;
            s1_bits_q <= '0;
            s1_nb_q   <= '0;
            buf_q     <= '0;
            fill_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_val_q  <= s1_val_d;
            s1_bits_q <= s1_bits_d;
            s1_nb_q   <= s1_nb_d;
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_huf_fix_enc.sv
// Bench for huf_fix_enc: directed and random token streams compared against a
// bit-level deflate model built straight from the fixed-Huffman tables.
module tb_huf_fix_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, done_o, val_i, flg_lit_i, flg_lst_i;
    logic [7:0]  dat_lit_i;
    logic [8:0]  dat_len_i;
    logic [15:0] dat_dst_i;
    logic        val_o, lst_o;
    logic [31:0] dat_o;
    logic [2:0]  byt_o;

    huf_fix_enc dut (
        .clk(clk), .rst(rst), .start_i(start_i), .done_o(done_o),
        .val_i(val_i), .flg_lit_i(flg_lit_i), .dat_lit_i(dat_lit_i),
        .dat_len_i(dat_len_i), .dat_dst_i(dat_dst_i), .flg_lst_i(flg_lst_i),
        .val_o(val_o), .dat_o(dat_o), .byt_o(byt_o), .lst_o(lst_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: only ever appends, so tests remember start indices.
    logic [31:0] gw[$];
    int          gb[$];
    bit          gl[$];
    int          cyc = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (val_o) begin
            gw.push_back(dat_o);
            gb.push_back(int'(byt_o));
            gl.push_back(lst_o);
            if (lst_o) last_cyc = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Token list and reference model.
    bit       tq_lit[$];
    int       tq_v[$], tq_len[$], tq_dst[$];
    bit       eb[$];

    localparam int LBASE[20] = '{11, 13, 15, 17, 19, 23, 27, 31, 35, 43, 51, 59,
                                 67, 83, 99, 115, 131, 163, 195, 227};
    localparam int LEXT[20]  = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5};

    function automatic int dext(input int c);
        return (c < 4) ? 0 : (c - 2) / 2;
    endfunction

    function automatic int dbase(input int c);
        if (c < 4) return c + 1;
        if (c % 2 == 0) return (1 << (dext(c) + 1)) + 1;
        return 3 * (1 << dext(c)) + 1;
    endfunction

    task automatic put_lsb(input int v, input int n);
        for (int i = 0; i < n; i++) eb.push_back(bit'((v >> i) & 1));
    endtask

    task automatic put_msb(input int v, input int n);
        for (int i = n - 1; i >= 0; i--) eb.push_back(bit'((v >> i) & 1));
    endtask

    task automatic put_sym(input int sym);
        if (sym < 144)      put_msb(48 + sym, 8);
        else if (sym < 256) put_msb(400 + sym - 144, 9);
        else if (sym < 280) put_msb(sym - 256, 7);
        else                put_msb(192 + sym - 280, 8);
    endtask

    task automatic model_build();
        int sym, ebn, ev, idx, c;
        eb.delete();
        put_lsb(3, 3);
        foreach (tq_lit[t]) begin
            if (tq_lit[t]) begin
                put_sym(tq_v[t]);
            end else begin
                ebn = 0; ev = 0;
                if (tq_len[t] == 258) sym = 285;
                else if (tq_len[t] <= 10) sym = 254 + tq_len[t];
                else begin
                    idx = 0;
                    for (int i = 0; i < 20; i++) if (tq_len[t] >= LBASE[i]) idx = i;
                    sym = 265 + idx;
                    ebn = LEXT[idx];
                    ev  = tq_len[t] - LBASE[idx];
                end
                put_sym(sym);
                put_lsb(ev, ebn);
                c = 0;
                for (int i = 0; i < 30; i++) if (dbase(i) <= tq_dst[t]) c = i;
                put_msb(c, 5);
                put_lsb(tq_dst[t] - dbase(c), dext(c));
            end
        end
        put_sym(256);
        while (eb.size() % 8 != 0) eb.push_back(1'b0);
    endtask

    task automatic clr_tok();
        tq_lit.delete(); tq_v.delete(); tq_len.delete(); tq_dst.delete();
    endtask

    task automatic add_lit(input int v);
        tq_lit.push_back(1'b1); tq_v.push_back(v); tq_len.push_back(3); tq_dst.push_back(1);
    endtask

    task automatic add_ld(input int l, input int d);
        tq_lit.push_back(1'b0); tq_v.push_back(0); tq_len.push_back(l); tq_dst.push_back(d);
    endtask

    task automatic compare_block(input string nm, input int w0, input int d0);
        int nbits, nw, idx;
        logic [31:0] ew;
        nbits = eb.size();
        nw    = (nbits + 31) / 32;
        chk({nm, " nwords"}, gw.size() - w0, nw);
        for (int i = 0; i < nw; i++) begin
            ew = '0;
            for (int b = 0; b < 32; b++) begin
                idx = 32 * i + b;
                if (idx < nbits) ew[b] = eb[idx];
            end
            chk({nm, " word"}, (w0 + i < gw.size()) ? gw[w0 + i] : 32'hxxxxxxxx, ew);
            chk({nm, " byt"}, (w0 + i < gb.size()) ? gb[w0 + i] : -1,
                (i == nw - 1) ? (nbits - 32 * i) / 8 : 4);
            chk({nm, " lst"}, (w0 + i < gl.size()) ? gl[w0 + i] : 1'bx, i == nw - 1);
        end
        chk({nm, " done_cnt"}, done_cnt - d0, 1);
        chk({nm, " done_lat"}, done_cyc, last_cyc + 1);
    endtask

    task automatic drive_tok(input int t, input bit lst);
        val_i     = 1'b1;
        flg_lit_i = tq_lit[t];
        dat_lit_i = 8'(tq_v[t]);
        dat_len_i = 9'(tq_len[t]);
        dat_dst_i = 16'(tq_dst[t]);
        flg_lst_i = lst;
    endtask

    task automatic run_block(input string nm, input bit gaps, input bit junk, output int w0);
        int d0, n;
        model_build();
        w0 = gw.size();
        d0 = done_cnt;
        n  = tq_lit.size();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        if (junk) begin
            val_i = 1'b1; flg_lit_i = 1'b1; dat_lit_i = 8'($urandom); flg_lst_i = 1'b1;
        end
        @(posedge clk); #1 val_i = 1'b0; flg_lst_i = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    val_i = 1'b0;
                    if (junk && $urandom_range(0, 3) == 0) start_i = 1'b1;
                    @(posedge clk); #1 start_i = 1'b0;
                end
            end
            drive_tok(t, t == n - 1);
            @(posedge clk); #1;
        end
        val_i = junk; flg_lst_i = junk; flg_lit_i = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        val_i = 1'b0; flg_lst_i = 1'b0;
        for (int i = 0; i < 500 && done_cnt == d0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1 compare_block(nm, w0, d0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, d0;
        logic [31:0] g;
        rst = 1'b1; start_i = 1'b0; val_i = 1'b0; flg_lit_i = 1'b0;
        dat_lit_i = '0; dat_len_i = '0; dat_dst_i = '0; flg_lst_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst val_o", val_o, 0);
        chk("rst done_o", done_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle val_o", val_o, 0);
        chk("idle dat_o", dat_o, 0);
        chk("idle byt_o", byt_o, 0);
        chk("idle lst_o", lst_o, 0);

        clr_tok(); add_lit(0);
        run_block("lit00", 0, 0, w0);
        g = (gw.size() > w0) ? gw[w0] : 32'hxxxxxxxx;
        chk("lit00 const", g, 32'h00000063);

        clr_tok(); add_lit(8'h61);
        run_block("lit61", 0, 0, w0);
        g = (gw.size() > w0) ? gw[w0] : 32'hxxxxxxxx;
        chk("lit61 const", g, 32'h0000044B);

        clr_tok(); add_lit(0); add_ld(3, 1);
        run_block("len3", 0, 0, w0);
        g = (gw.size() > w0) ? gw[w0] : 32'hxxxxxxxx;
        chk("len3 const", g, 32'h00020063);

        clr_tok(); add_ld(258, 32768);
        run_block("max", 0, 0, w0);

        clr_tok(); add_ld(10, 4); add_ld(11, 5); add_ld(257, 24577); add_ld(227, 24576);
        add_lit(143); add_lit(144); add_lit(255);
        run_block("edges", 0, 1, w0);

        clr_tok();
        for (int i = 0; i < 256; i++) add_lit(8'h90);
        run_block("lit90x256", 0, 0, w0);
        chk("lit90x256 total", gw.size() - w0, 73);

        // Reset while tokens are still in flight must leave nothing behind.
        w0 = gw.size(); d0 = done_cnt;
        clr_tok(); add_lit(8'h90); add_lit(8'h90);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(posedge clk); #1 drive_tok(0, 1'b0);
        @(posedge clk); #1 drive_tok(1, 1'b0);
        @(posedge clk); #1 rst = 1'b1; val_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rstmid words", gw.size() - w0, 0);
        chk("rstmid done", done_cnt - d0, 0);

        clr_tok(); add_lit(0);
        run_block("post_rst", 0, 0, w0);
        g = (gw.size() > w0) ? gw[w0] : 32'hxxxxxxxx;
        chk("post_rst const", g, 32'h00000063);

        for (int r = 0; r < 10; r++) begin
            clr_tok();
            repeat ($urandom_range(1, 40)) begin
                if ($urandom_range(0, 1) == 0) add_lit($urandom_range(0, 255));
                else begin
                    int l, d;
                    case ($urandom_range(0, 4))
                        0: l = 3;
                        1: l = 258;
                        default: l = $urandom_range(3, 258);
                    endcase
                    case ($urandom_range(0, 4))
                        0: d = 1;
                        1: d = 32768;
                        default: d = $urandom_range(1, 32768);
                    endcase
                    add_ld(l, d);
                end
            end
            run_block($sformatf("rnd%0d", r), 1, 1, w0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/huf_fix_enc.md
Name: huf_fix_enc

Overview:
- Deflate fixed-Huffman (BTYPE=01) encoder sitting directly downstream of lz77_top.
- Consumes the LZ77 token stream (literal, or length/distance pair) one token per cycle and converts each token to fixed Huffman codes plus extra bits.
- Packs the result LSB-first into a deflate bitstream and emits 32-bit words toward the zlib/IDAT wrapper.
- Emits the block header at start, end-of-block (EOB) after the last token, and pads to a byte boundary.

Parameters:
- DATA_CHN_WD, 8, literal width
- SIZE_LEN_WD, 9, match length width (3..258)
- SIZE_DST_WD, 16, match distance width (1..32768)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle pulse; begins a deflate block
- done_o  out  1  one-cycle pulse after the final word is emitted
- val_i  in  1  token valid; no backpressure, so a token is accepted every cycle val_i=1
- flg_lit_i  in  1  1: literal token; 0: length/distance token
- dat_lit_i  in  DATA_CHN_WD  literal byte
- dat_len_i  in  SIZE_LEN_WD  match length
- dat_dst_i  in  SIZE_DST_WD  match distance
- flg_lst_i  in  1  last token of the stream
- val_o  out  1  output word valid
- dat_o  out  32  packed bits; bit0 is the first stream bit; byte0 = dat_o[7:0]
- byt_o  out  3  valid bytes in dat_o (1..4); always 4 except on the last word
- lst_o  out  1  marks the last output word

Behaviour:
- Reset: all outputs 0; bit buffer cleared; FSM goes to IDLE. Reset mid-block abandons the block with no partial word emitted.
- FSM states:
  - IDLE: start_i moves to HDR.
  - HDR: pushes 3 bits (BFINAL=1, then BTYPE=01 LSB-first, giving stream bits 1,1,0) in one cycle, then moves to RUN.
  - RUN: accepts tokens. A token with flg_lst_i=1 moves to EOB after it is pushed.
  - EOB: pushes the 7-bit zero code, then moves to FLUSH.
  - FLUSH: drains the buffer, pads with zeros to a byte boundary, and emits the last word with lst_o=1. It then pulses done_o the next cycle and returns to IDLE.
- Ignored inputs: val_i outside RUN, and start_i outside IDLE.
- Huffman codes are transmitted MSB-first, so code bits are reversed before packing. Extra bits are packed LSB-first.
- Literal/length codes:
  - 0..143: 8 bits, 0x30+v
  - 144..255: 9 bits, 0x190+(v-144)
  - 256..279: 7 bits, v-256
  - 280..287: 8 bits, 0xC0+(v-280)
- Length to code:
  - 3..10 map to 257..264 with 0 extra bits.
  - 265..284 use base lengths 11,13,15,17,19,23,27,31,35,43,51,59,67,83,99,115,131,163,195,227, with extra bits 1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4,5,5,5,5.
  - 258 maps to 285 with 0 extra bits.
- Distance: 5-bit code d, written MSB-first.
  - Codes 0..3 cover distances 1..4 with 0 extra bits.
  - Codes 2k+2 and 2k+3 carry k extra bits, base 2^(k+1)+1 and 3*2^k+1 respectively, up to code 29 (base 24577, 13 extra bits).
  - Extra-bit value is dist-base.
- Pipeline:
  - Stage 1 registers the token and does the table lookup.
  - Stage 2 concatenates at most 31 bits (8+5+5+13) and appends them to a 64-bit buffer at the current fill count.
  - A token arriving at cycle N has its bits in the buffer at N+2.
- Output: when fill ≥32, emit the low 32 bits with val_o=1 and byt_o=4 the same cycle, shift the buffer, and reduce fill by 32. Fill stays below 63, so no overflow at full input rate.
- Simultaneous emit and append in one cycle: shift first, then append.
- Illegal inputs (length <3 or >258, distance 0): the output is unspecified, but the FSM must not hang.

Test Plan:
- start, then literal 0x00 with flg_lst=1 -> exactly one word: dat_o=0x00000063, byt_o=3, lst_o=1; done_o one cycle later.
- start, then literal 0x61 with lst -> dat_o=0x0000044B, byt_o=3, lst_o=1.
- start, literal 0x00, then len=3/dst=1 with lst -> dat_o=0x00020063, byt_o=4, lst_o=1 (30 bits + 2 pad).
- len=258/dst=32768 token -> 26 bits pushed: code 0xC5 reversed, dist code 11101 reversed, 13 ones. Check against a golden model from a zlib raw-deflate dump of filter_o_scanlines.dat.
- 256 consecutive literals 0x90 (9 bits each) at full rate -> no token lost; 72 words with val_o=1 and byt_o=4 before the final word; inflate of the output reproduces the input.
- rst asserted in RUN mid-word -> val_o/done_o stay 0 and fill cleared; a new start yields a correct 0x63-style header.
